// File: rtl/forwarding_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : forwarding_hazard_unit
// Description : Operand forwarding selector and load-use stall controller.
//               For every decode read port the youngest producer stage that
//               writes the same register is selected. Its data, a hit flag
//               and the stage index are registered with one cycle latency.
//               When the selected source is stage 0 and that stage holds a
//               load whose data is not yet available, the port reports no
//               hit. An IDLE/STALL machine then raises stall for LOAD_LAT
//               consecutive cycles.
// Ports       : clock       - rising-edge clock
//               reset_n     - synchronous active-low reset
//               flush       - drop pending hazard/forwarding state
//               rd_addr/en  - decode read ports (NUM_RD)
//               wr_addr/en  - producer stage destinations (NUM_ST, 0 youngest)
//               wr_data     - producer stage results
//               st_is_load  - stage result not yet available (stage 0 used)
//               fwd_data/hit/src - registered forwarding result per port
//               stall       - registered freeze request for fetch/decode
// Revision    : 1.0 - initial release
// ============================================================================
module forwarding_hazard_unit #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 3,
    parameter int NUM_RD   = 2,
    parameter int NUM_ST   = 3,
    parameter int LOAD_LAT = 1,
    parameter int ZERO_REG = 0,
    localparam int SRC_W   = (NUM_ST > 1) ? $clog2(NUM_ST) : 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       flush,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_ST*ADDR_W-1:0]   wr_addr,
    input  logic [NUM_ST-1:0]          wr_en,
    input  logic [NUM_ST*DATA_W-1:0]   wr_data,
    input  logic [NUM_ST-1:0]          st_is_load,
    output logic [NUM_RD*DATA_W-1:0]   fwd_data,
    output logic [NUM_RD-1:0]          fwd_hit,
    output logic [NUM_RD*SRC_W-1:0]    fwd_src,
    output logic                       stall
);

    localparam logic [3:0] C_LOAD_LAT_M1 = 4'(LOAD_LAT - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_STALL = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [3:0]                 cnt_q, cnt_d;
    logic [NUM_RD*DATA_W-1:0]   fwd_data_q, fwd_data_d;
    logic [NUM_RD-1:0]          fwd_hit_q, fwd_hit_d;
    logic [NUM_RD*SRC_W-1:0]    fwd_src_q, fwd_src_d;
    logic [NUM_RD-1:0]          load_use_d;
    logic                       hazard_d;

    // Only the youngest stage's load flag matters; the rest are intentionally
    // left unconnected.
    logic                       unused_load_flags;
    assign unused_load_flags = ^st_is_load;

    // ------------------------------------------------------------------------
    // Per-port source selection
    // ------------------------------------------------------------------------
    for (genvar k = 0; k < NUM_RD; k++) begin : g_port
        logic [ADDR_W-1:0] addr;
        logic              zero_block;
        logic [NUM_ST-1:0] match;
        logic [SRC_W-1:0]  sel_src;
        logic [DATA_W-1:0] sel_data;
        logic              found;

        assign addr       = rd_addr[k*ADDR_W +: ADDR_W];
        assign zero_block = (ZERO_REG != 0) && (addr == '0);

        for (genvar s = 0; s < NUM_ST; s++) begin : g_stage
            assign match[s] = rd_en[k] & wr_en[s] & ~zero_block &
                              (addr == wr_addr[s*ADDR_W +: ADDR_W]);
        end

        // Scan oldest to youngest so the youngest match overwrites. Disabled
        // stages never match, so they cannot shadow an older producer.
        always_comb begin
            sel_src  = '0;
            sel_data = '0;
            for (int s = NUM_ST - 1; s >= 0; s--) begin
                if (match[s]) begin
                    sel_src  = SRC_W'(s);
                    sel_data = wr_data[s*DATA_W +: DATA_W];
                end
            end
        end

        assign found = |match;

        // Stage 0 is the youngest, so a stage-0 match is always the winner.
        assign load_use_d[k] = match[0] & st_is_load[0];

        assign fwd_hit_d[k]                    = found & ~load_use_d[k];
        assign fwd_data_d[k*DATA_W +: DATA_W]  = load_use_d[k] ? '0 : sel_data;
        assign fwd_src_d[k*SRC_W +: SRC_W]     = sel_src;
    end

    assign hazard_d = |load_use_d;

    // ------------------------------------------------------------------------
    // Stall controller
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (hazard_d) begin
                    state_d = S_STALL;
                    cnt_d   = C_LOAD_LAT_M1;
                end
            end
            S_STALL: begin
                // Hazards are ignored here so a stall is never stretched.
                if (cnt_q == 4'd0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            fwd_data_q <= '0;
            fwd_hit_q  <= '0;
            fwd_src_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (flush) begin
                fwd_data_q <= '0;
                fwd_hit_q  <= '0;
                fwd_src_q  <= '0;
            end else begin
                fwd_data_q <= fwd_data_d;
                fwd_hit_q  <= fwd_hit_d;
                fwd_src_q  <= fwd_src_d;
            end
        end
    end

    assign fwd_data = fwd_data_q;
    assign fwd_hit  = fwd_hit_q;
    assign fwd_src  = fwd_src_q;
    assign stall    = (state_q == S_STALL);

endmodule
`default_nettype wire

// File: tb/tb_forwarding_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_forwarding_hazard_unit
// Description : Self-checking bench for forwarding_hazard_unit at
//               NUM_RD=3, NUM_ST=4, DATA_W=32, LOAD_LAT=2, ZERO_REG=1.
//               Directed scenarios followed by random traffic, all compared
//               against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_forwarding_hazard_unit;

    localparam int DW = 32;
    localparam int AW = 3;
    localparam int NR = 3;
    localparam int NS = 4;
    localparam int LL = 2;
    localparam int ZR = 1;
    localparam int SW = 2;

    logic               clock = 1'b0;
    logic               reset_n;
    logic               flush;
    logic [NR*AW-1:0]   rd_addr;
    logic [NR-1:0]      rd_en;
    logic [NS*AW-1:0]   wr_addr;
    logic [NS-1:0]      wr_en;
    logic [NS*DW-1:0]   wr_data;
    logic [NS-1:0]      st_is_load;
    logic [NR*DW-1:0]   fwd_data;
    logic [NR-1:0]      fwd_hit;
    logic [NR*SW-1:0]   fwd_src;
    logic               stall;

    always #5 clock = ~clock;

    forwarding_hazard_unit #(
        .DATA_W   (DW),
        .ADDR_W   (AW),
        .NUM_RD   (NR),
        .NUM_ST   (NS),
        .LOAD_LAT (LL),
        .ZERO_REG (ZR)
    ) u_dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .wr_addr    (wr_addr),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .st_is_load (st_is_load),
        .fwd_data   (fwd_data),
        .fwd_hit    (fwd_hit),
        .fwd_src    (fwd_src),
        .stall      (stall)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state: number of stall cycles still to be shown.
    int               stall_left = 0;
    logic [NR*DW-1:0] exp_data;
    logic [NR-1:0]    exp_hit;
    logic [NR*SW-1:0] exp_src;
    logic             exp_stall;

    task automatic check_val(input string tag, input logic [127:0] obs,
                             input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Predict the outputs that the next rising edge will produce.
    task automatic model_step();
        logic hz;
        hz        = 1'b0;
        exp_data  = '0;
        exp_hit   = '0;
        exp_src   = '0;
        if (!reset_n || flush) begin
            stall_left = 0;
        end else begin
            for (int k = 0; k < NR; k++) begin
                int src;
                logic [AW-1:0] a;
                a   = rd_addr[k*AW +: AW];
                src = -1;
                for (int s = 0; s < NS; s++) begin
                    if (src < 0 && rd_en[k] && wr_en[s] &&
                        a == wr_addr[s*AW +: AW] && !(ZR == 1 && a == 0))
                        src = s;
                end
                if (src == 0 && st_is_load[0]) begin
                    hz = 1'b1;
                end else if (src >= 0) begin
                    exp_data[k*DW +: DW] = wr_data[src*DW +: DW];
                    exp_hit[k]           = 1'b1;
                    exp_src[k*SW +: SW]  = SW'(src);
                end
            end
            if (stall_left > 0) stall_left--;
            else if (hz)        stall_left = LL;
        end
        exp_stall = (stall_left > 0);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        check_val("fwd_data", fwd_data, exp_data);
        check_val("fwd_hit",  fwd_hit,  exp_hit);
        check_val("fwd_src",  fwd_src,  exp_src);
        check_val("stall",    stall,    exp_stall);
    endtask

    task automatic clear_inputs();
        reset_n    = 1'b1;
        flush      = 1'b0;
        rd_addr    = '0;
        rd_en      = '0;
        wr_addr    = '0;
        wr_en      = '0;
        wr_data    = '0;
        st_is_load = '0;
    endtask

    // Stage 0 loads r3, port 1 reads r3.
    task automatic set_load_use();
        clear_inputs();
        wr_en[0]          = 1'b1;
        wr_addr[0 +: AW]  = 3'd3;
        wr_data[0 +: DW]  = 32'hDEAD_BEEF;
        st_is_load[0]     = 1'b1;
        rd_en[1]          = 1'b1;
        rd_addr[AW +: AW] = 3'd3;
    endtask

    // Port 2 reads r6 produced by stage 1: a plain forwarding hit.
    task automatic add_port2_hit();
        rd_en[2]            = 1'b1;
        rd_addr[2*AW +: AW] = 3'd6;
        wr_en[1]            = 1'b1;
        wr_addr[AW +: AW]   = 3'd6;
        wr_data[DW +: DW]   = 32'h0000_6666;
    endtask

    initial begin
        clear_inputs();
        reset_n = 1'b0;
        cycle();
        cycle();
        check_val("reset_stall", stall, 1'b0);
        check_val("reset_hit", fwd_hit, '0);

        // Youngest of three matching producers wins.
        clear_inputs();
        rd_en[0]         = 1'b1;
        rd_addr[0 +: AW] = 3'd5;
        wr_en            = 4'b0111;
        for (int s = 0; s < 3; s++) wr_addr[s*AW +: AW] = 3'd5;
        wr_data[0 +: DW]    = 32'h1111;
        wr_data[DW +: DW]   = 32'h2222;
        wr_data[2*DW +: DW] = 32'h3333;
        cycle();
        check_val("prio_data", fwd_data[0 +: DW], 32'h1111);
        check_val("prio_src",  fwd_src[0 +: SW], 2'd0);
        check_val("prio_hit",  fwd_hit[0], 1'b1);

        // Same address in stage 0 but disabled: falls through to stage 1.
        wr_en             = 4'b0010;
        wr_data[DW +: DW] = 32'hABCD;
        cycle();
        check_val("fall_data", fwd_data[0 +: DW], 32'hABCD);
        check_val("fall_src",  fwd_src[0 +: SW], 2'd1);

        // Load-use: stall exactly LOAD_LAT cycles.
        set_load_use();
        cycle();
        check_val("lu_stall_t1", stall, 1'b1);
        check_val("lu_hit_t1", fwd_hit[1], 1'b0);
        clear_inputs();
        cycle();
        check_val("lu_stall_t2", stall, 1'b1);
        cycle();
        check_val("lu_stall_t3", stall, 1'b0);

        // Hazard held continuously: ignored on the last STALL cycle,
        // re-triggers in the first IDLE cycle.
        set_load_use();
        cycle();
        cycle();
        check_val("hold_stall_2", stall, 1'b1);
        cycle();
        check_val("hold_stall_3", stall, 1'b0);
        cycle();
        check_val("hold_retrig", stall, 1'b1);
        clear_inputs();
        cycle();
        cycle();

        // Zero register is never forwarded.
        clear_inputs();
        rd_en[0]          = 1'b1;
        wr_en[1]          = 1'b1;
        wr_data[DW +: DW] = 32'h5A5A;
        cycle();
        check_val("zero_hit",  fwd_hit[0], 1'b0);
        check_val("zero_data", fwd_data[0 +: DW], 32'h0);

        // Flush in the first STALL cycle.
        set_load_use();
        cycle();
        check_val("fl_pre_stall", stall, 1'b1);
        clear_inputs();
        add_port2_hit();
        flush = 1'b1;
        cycle();
        check_val("fl_stall", stall, 1'b0);
        check_val("fl_hit", fwd_hit, '0);

        // Reset in the middle of a stall.
        set_load_use();
        cycle();
        clear_inputs();
        add_port2_hit();
        reset_n = 1'b0;
        flush   = 1'b1;
        cycle();
        check_val("rs_stall", stall, 1'b0);
        check_val("rs_hit", fwd_hit, '0);
        check_val("rs_data", fwd_data, '0);

        // Random traffic.
        for (int n = 0; n < 10000; n++) begin
            reset_n    = ($urandom_range(0, 199) != 0);
            flush      = ($urandom_range(0, 49) == 0);
            rd_en      = NR'($urandom);
            wr_en      = NS'($urandom);
            st_is_load = NS'($urandom_range(0, 3) == 0 ? $urandom : 0);
            for (int k = 0; k < NR; k++) rd_addr[k*AW +: AW] = AW'($urandom);
            for (int s = 0; s < NS; s++) begin
                wr_addr[s*AW +: AW] = AW'($urandom);
                wr_data[s*DW +: DW] = $urandom;
            end
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/forwarding_hazard_unit.md
FORWARDING_HAZARD_UNIT -- requirements
Module: forwarding_hazard_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning forwarded data width.
REQ-002 SHALL have parameter ADDR_W, default 3, meaning register address width.
REQ-003 SHALL have parameter NUM_RD, default 2, meaning number of decode-stage read ports.
REQ-004 SHALL have parameter NUM_ST, default 3, meaning number of producer stages (index 0 youngest, i.e. p3; NUM_ST-1 oldest).
REQ-005 SHALL have parameter LOAD_LAT, default 1 (range 1..15), meaning stall cycles inserted per load-use hazard.
REQ-006 SHALL have parameter ZERO_REG, default 0, meaning 1 = address 0 is hardwired zero and never forwarded.
REQ-007 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-008 SHALL have port reset_n  input  1  reset is synchronous and active-low.
REQ-009 SHALL have port flush  input  1  discard pending hazard and forwarding results.
REQ-010 SHALL have port rd_addr  input  NUM_RD*ADDR_W  read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-011 SHALL have port rd_en  input  NUM_RD  per-port read valid.
REQ-012 SHALL have port wr_addr  input  NUM_ST*ADDR_W  destination address per stage.
REQ-013 SHALL have port wr_en  input  NUM_ST  per-stage register write enable.
REQ-014 SHALL have port wr_data  input  NUM_ST*DATA_W  result data per stage.
REQ-015 SHALL have port st_is_load  input  NUM_ST  per-stage flag: data not yet available (only stage 0 is considered).
REQ-016 SHALL have port fwd_data  output  NUM_RD*DATA_W  registered forwarded data per port.
REQ-017 SHALL have port fwd_hit  output  NUM_RD  registered: port k uses fwd_data instead of register file.
REQ-018 SHALL have port fwd_src  output  NUM_RD*$clog2(NUM_ST)  registered index of source stage (0 when no hit).
REQ-019 SHALL have port stall  output  1  registered: freeze fetch/decode stages.

Function
REQ-020 SHALL, per port k, compute a match against stage s when rd_en[k]=1, wr_en[s]=1, rd_addr[k]=wr_addr[s], and not (ZERO_REG=1 and rd_addr[k]=0).
REQ-021 SHALL select the youngest matching stage (lowest s); a stage with equal address but wr_en=0 SHALL NOT block older stages.
REQ-022 SHALL, on a hit, register fwd_data[k]=wr_data[s], fwd_hit[k]=1, fwd_src[k]=s one cycle after inputs are sampled (latency 1).
REQ-023 SHALL, on no hit, register fwd_data[k]=0, fwd_hit[k]=0, fwd_src[k]=0.
REQ-024 SHALL detect a load-use hazard when any port's selected source is stage 0 and st_is_load[0]=1; such a port SHALL register fwd_hit[k]=0 and fwd_data[k]=0.
REQ-025 SHALL implement FSM IDLE/STALL with down-counter cnt of 4 bits.
REQ-026 SHALL, in IDLE with hazard detected, go to STALL, set cnt=LOAD_LAT-1, assert stall next cycle.
REQ-027 SHALL, in STALL, hold stall=1; when cnt=0 return to IDLE with stall=0 next cycle, else decrement cnt; stall is high exactly LOAD_LAT consecutive cycles.
REQ-028 SHALL ignore hazard detection while in STALL (no extension, no re-trigger on the final STALL cycle); a hazard present in the first IDLE cycle after STALL SHALL re-trigger.
REQ-029 SHALL continue updating forwarding outputs every cycle regardless of FSM state.
REQ-030 SHALL, when flush=1 (and reset_n=1), go to IDLE, drive stall=0, and clear all fwd_* outputs next cycle; flush takes priority over hazard detection.

Reset
REQ-031 SHALL, when reset_n=0 at a rising edge, set FSM=IDLE, cnt=0, stall=0, fwd_data=0, fwd_hit=0, fwd_src=0; reset overrides flush and a mid-STALL reset terminates the stall next cycle.

Verification
REQ-032 SHALL verify priority: rd_addr[0]=5, stages 0,1,2 all write 5 with data 0x1111/0x2222/0x3333 -> next cycle fwd_data[0]=0x1111, fwd_src[0]=0, fwd_hit[0]=1.
REQ-033 SHALL verify disabled-stage fallthrough: stage 0 addr 5 wr_en=0, stage 1 addr 5 wr_en=1 data 0xABCD -> fwd_data[0]=0xABCD, fwd_src[0]=1.
REQ-034 SHALL verify load-use with LOAD_LAT=2: stage 0 load to 3, rd_addr[1]=3 -> stall high exactly 2 cycles starting at cycle t+1, fwd_hit[1]=0 at t+1.
REQ-035 SHALL verify ZERO_REG=1: rd_addr=0 matching stage 1 write -> fwd_hit=0, fwd_data=0.
REQ-036 SHALL verify flush and reset mid-STALL: flush=1 in first STALL cycle -> stall=0 next cycle; reset_n=0 mid-STALL -> all outputs 0 next cycle.
REQ-037 SHALL verify parametrisation at NUM_RD=3, NUM_ST=4, DATA_W=32 with random stimulus against a behavioural model, no mismatches over 10000 cycles.
